// File: rtl/mem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// mem_fetch_ctrl
//
// Initiator side of the command/data memory handshake. Fetches a 16-bit
// instruction from command memory, reads up to two operands from data memory,
// executes one ALU operation and optionally writes the result back using the
// two-beat write protocol. Only one memory request is outstanding at a time.
//
// Instruction word: op=[15:13] dst=[12:9] srcA=[8:5] srcB=[4:1] wb=[0]
//   op 000 add, 001 sub (carry=borrow), 010 and, 011 or, 100 xor,
//      101 pass A, 110 nop, 111 halt
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         one-cycle pulse; starts at pc=0 from IDLE or HALT
//   give_com      command read strobe, adr = pc
//   give_data     data read strobe, adr = operand address
//   write         write beat 1 marker, adr = destination address
//   adr           request address; carries the result on write beat 2
//   dv            memory response valid (one-cycle pulse)
//   com           instruction word, valid with dv after give_com
//   data          operand, valid with dv after give_data
//   busy          high in every state except IDLE and HALT
//   halted        high in HALT
//   err           sticky dv-timeout flag, cleared by reset or start
//   pc            address of the current instruction
//   result        last computed result
//   carry         carry/borrow of the last add/sub, 0 for other ops
//   result_valid  high for the single EXEC cycle
// -----------------------------------------------------------------------------
module mem_fetch_ctrl #(
    parameter int ADR_W    = 4,
    parameter int DAT_W    = 4,
    parameter int PROG_LEN = 2,
    parameter int TIMEOUT  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             give_com,
    output logic             give_data,
    output logic             write,
    output logic [ADR_W-1:0] adr,
    input  logic             dv,
    input  logic [15:0]      com,
    input  logic [DAT_W-1:0] data,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [ADR_W-1:0] pc,
    output logic [DAT_W-1:0] result,
    output logic             carry,
    output logic             result_valid
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_RDA_REQ,
        S_RDA_WAIT,
        S_RDB_REQ,
        S_RDB_WAIT,
        S_EXEC,
        S_WR_ADR,
        S_WR_DAT,
        S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [15:0]      r_instr;
    logic [DAT_W-1:0] r_a;
    logic [ADR_W-1:0] r_pc;
    logic [DAT_W-1:0] r_result;
    logic             r_carry;
    logic             r_err;
    logic [CNT_W-1:0] r_wait_cnt;

    logic [2:0]       w_op;
    logic [3:0]       w_dst;
    logic [3:0]       w_src_a;
    logic [3:0]       w_src_b;
    logic             w_wb;
    logic             w_com_no_operands;
    logic             w_is_wait;
    logic             w_timeout;
    logic             w_can_start;
    logic [ADR_W-1:0] w_pc_next;
    logic [DAT_W:0]   w_sum;
    logic [DAT_W:0]   w_diff;
    logic [DAT_W-1:0] w_alu_res;
    logic             w_alu_carry;

    assign w_op    = r_instr[15:13];
    assign w_dst   = r_instr[12:9];
    assign w_src_a = r_instr[8:5];
    assign w_src_b = r_instr[4:1];
    assign w_wb    = r_instr[0];

    // nop and halt skip both operand reads; decided from the live word on dv
    assign w_com_no_operands = (com[15:14] == 2'b11);

    assign w_is_wait = (r_state == S_FETCH_WAIT) || (r_state == S_RDA_WAIT) ||
                       (r_state == S_RDB_WAIT);

    // Counter holds the number of dv-less cycles already spent in this WAIT
    assign w_timeout = w_is_wait && !dv && (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    assign w_can_start = start && ((r_state == S_IDLE) || (r_state == S_HALT));

    assign w_pc_next = (r_pc == ADR_W'(PROG_LEN - 1)) ? '0 : r_pc + ADR_W'(1);

    // Operand B is consumed straight from the data bus on its dv cycle, so the
    // result is already registered while the FSM sits in EXEC.
    assign w_sum  = {1'b0, r_a} + {1'b0, data};
    assign w_diff = {1'b0, r_a} - {1'b0, data};

    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (w_op)
            OP_ADD:  {w_alu_carry, w_alu_res} = w_sum;
            OP_SUB:  {w_alu_carry, w_alu_res} = w_diff;
            OP_AND:  w_alu_res = r_a & data;
            OP_OR:   w_alu_res = r_a | data;
            OP_XOR:  w_alu_res = r_a ^ data;
            OP_PASS: w_alu_res = r_a;
            default: w_alu_res = '0;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the values from before this edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block is given a default before the case, so
    // no path through it leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        give_com     = 1'b0;
        give_data    = 1'b0;
        write        = 1'b0;
        adr          = '0;
        result_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_FETCH_REQ;
            end
            S_FETCH_REQ: begin
                give_com     = 1'b1;
                adr          = r_pc;
                w_next_state = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                if (dv) begin
                    w_next_state = w_com_no_operands ? S_EXEC : S_RDA_REQ;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                end
            end
            S_RDA_REQ: begin
                give_data    = 1'b1;
                adr          = ADR_W'(w_src_a);
                w_next_state = S_RDA_WAIT;
            end
            S_RDA_WAIT: begin
                if (dv)             w_next_state = S_RDB_REQ;
                else if (w_timeout) w_next_state = S_HALT;
            end
            S_RDB_REQ: begin
                give_data    = 1'b1;
                adr          = ADR_W'(w_src_b);
                w_next_state = S_RDB_WAIT;
            end
            S_RDB_WAIT: begin
                if (dv)             w_next_state = S_EXEC;
                else if (w_timeout) w_next_state = S_HALT;
            end
            S_EXEC: begin
                result_valid = 1'b1;
                if (w_op == OP_HALT) begin
                    w_next_state = S_HALT;
                end else if (w_wb && (w_op != OP_NOP)) begin
                    w_next_state = S_WR_ADR;
                end else begin
                    w_next_state = S_FETCH_REQ;
                end
            end
            S_WR_ADR: begin
                write        = 1'b1;
                adr          = ADR_W'(w_dst);
                w_next_state = S_WR_DAT;
            end
            S_WR_DAT: begin
                adr          = ADR_W'(r_result);
                w_next_state = S_FETCH_REQ;
            end
            S_HALT: begin
                if (start) w_next_state = S_FETCH_REQ;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr    <= '0;
            r_a        <= '0;
            r_pc       <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (w_is_wait && !dv) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else                  r_wait_cnt <= '0;

            if (w_timeout)        r_err <= 1'b1;
            else if (w_can_start) r_err <= 1'b0;

            // pc moves only when an instruction completes; halt and timeout keep it
            if (w_can_start) begin
                r_pc <= '0;
            end else if (((r_state == S_EXEC) || (r_state == S_WR_DAT)) &&
                         (w_next_state == S_FETCH_REQ)) begin
                r_pc <= w_pc_next;
            end

            if ((r_state == S_FETCH_WAIT) && dv) r_instr <= com;
            if ((r_state == S_RDA_WAIT) && dv)   r_a     <= data;
            if ((r_state == S_RDB_WAIT) && dv) begin
                r_result <= w_alu_res;
                r_carry  <= w_alu_carry;
            end
        end
    end

    assign busy   = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted = (r_state == S_HALT);
    assign err    = r_err;
    assign pc     = r_pc;
    assign result = r_result;
    assign carry  = r_carry;

endmodule

// File: doc/mem_fetch_ctrl.md
Name: mem_fetch_ctrl

Overview:
Initiator side of the command/data memory handshake: fetches 16-bit instructions from command memory, reads two 4-bit operands from data memory, executes a small ALU operation and writes the result back with the two-beat write protocol. It drives give_com/give_data/write/adr and consumes dv/com/data from the memory responder. It is the sequencing core of the cpu block. Only one memory request is outstanding at any time.

Parameters:
ADR_W, 4, width of adr, pc and operand/destination address fields
DAT_W, 4, data word width; results are truncated modulo 2^DAT_W
PROG_LEN, 2, number of command memory entries; pc wraps to 0 after PROG_LEN-1
TIMEOUT, 8, cycles to wait for dv before flagging err

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins execution at pc=0 when idle or halted
give_com  out  1  command read request pulse; adr holds pc
give_data  out  1  data read request pulse; adr holds operand address
write  out  1  write beat 1 marker; adr holds destination address
adr  out  ADR_W  request address; on write beat 2 it carries the result value
dv  in  1  response valid from memory, one-cycle pulse
com  in  16  instruction word, valid while dv=1 after give_com
data  in  DAT_W  operand, valid while dv=1 after give_data
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
err  out  1  sticky; set on dv timeout, cleared by reset or start
pc  out  ADR_W  address of the current instruction
result  out  DAT_W  last computed result
carry  out  1  carry/borrow of last add/sub; 0 for other ops
result_valid  out  1  one-cycle pulse in EXEC

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; give_com, give_data, write, adr, pc, result, carry, result_valid, err, halted=0. Reset mid-transaction abandons it: no write beat is issued afterwards.
- Instruction fields: op=com[15:13], dst=com[12:9], srcA=com[8:5], srcB=com[4:1], wb=com[0]. Instruction, operand A and operand B are latched on the dv cycle.
- States: IDLE -> (start) FETCH_REQ -> FETCH_WAIT -> RDA_REQ -> RDA_WAIT -> RDB_REQ -> RDB_WAIT -> EXEC -> WR_ADR -> WR_DAT -> FETCH_REQ (next pc).
- *_REQ: drive the request strobe for exactly one cycle with adr valid; all strobes are 0 in every other state.
- *_WAIT: advance on the first cycle with dv=1. The memory responds one cycle after the request, so a full instruction takes 9 cycles with write-back and 7 without.
- Ops: 000 add A+B, 001 sub A-B (carry=borrow), 010 and, 011 or, 100 xor, 101 pass A, 110 nop, 111 halt.
- For 110 and 111 no operand reads are performed: FETCH_WAIT goes straight to EXEC. 110 then advances pc; 111 enters HALT with pc unchanged.
- EXEC: result/carry registered and result_valid=1 for one cycle. If wb=1 and op is 000-101, go to WR_ADR; otherwise advance pc and go to FETCH_REQ.
- Write-back: WR_ADR drives write=1, adr=dst. WR_DAT drives write=0, adr=result. No dv is expected for writes, and the next request is not issued before the cycle after WR_DAT.
- pc increments after each instruction and wraps from PROG_LEN-1 to 0. Execution is continuous until halt.
- Timeout: in a WAIT state, a cycle counter reaching TIMEOUT without dv sets err=1 and enters HALT.
- dv received outside a WAIT state is ignored. start while busy is ignored. start in HALT clears err and halted and restarts from pc=0.

Test Plan:
- Data mem [2]=4, [3]=14; cmd[0]=000_0100_0010_0011_1, start -> give_com at pc 0; give_data at adr 2 then adr 3; result=2, carry=1; write=1 with adr=4, next cycle adr=2; data mem[4]=2; 9 cycles from FETCH_REQ to the next FETCH_REQ.
- cmd[1]=000_0110_0010_0011_0 -> result=2, result_valid pulse, write never asserted; pc wraps to 0 after this instruction.
- cmd = 001 (sub), A=3, B=5, wb=1 -> result=14, carry=1, mem[dst]=14; op 010 (and) with 12,10 -> result=8, carry=0.
- cmd = 111 halt -> no give_data; halted=1, busy=0, pc held. A start pulse then restarts at pc=0.
- Responder withholds dv after give_data -> after TIMEOUT (8) cycles err=1 and halted=1. Spurious dv pulses in IDLE cause no state change.
- rst_n=0 in the cycle between WR_ADR and WR_DAT -> no beat-2 adr value is issued; all outputs are 0 next cycle and the block is IDLE.
